// File: rtl/sap_ram16x8.sv
// sap_ram16x8: 16x8 program/data RAM fed by the MAR, with a valid/ready
// loader that fills all words from address 0 while prog is high.
//
// Ports:
//   clk, clr        clock (rising edge), async active-high reset
//   mar_addr        read/write address from the MAR (run mode)
//   bus_in          write data from the W bus (run mode)
//   ce_n, we        read strobe (active low), write enable (run mode)
//   prog            1 = program mode (loader), 0 = run mode
//   ld_valid/ld_data/ld_ready  loader byte handshake
//   ld_done         all words loaded; held until prog drops
//   ram_out/ram_oe  registered read data and its valid flag
//   parity_err      read parity mismatch (0 unless RAM_PARITY_EN)
//
// Build option: define RAM_PARITY_EN to store an even-parity bit per word
// and check it on every run-mode read.
module sap_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ce_n,
  input  logic              we,
  input  logic              prog,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ram_out,
  output logic              ram_oe,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] load_ptr, ptr_nx;
  logic              prog_q;
  logic              rdy_nx, done_nx;

  logic              run, accept;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_W-1:0]  wr_word, rd_word;

  logic [MEM_W-1:0]  mem [DEPTH];

  // Run-mode strobes only count in IDLE with prog low; anything else
  // belongs to the loader.
  assign run    = (state == IDLE) && !prog;
  assign accept = (state == LOAD) && prog
                  && ld_valid && ld_ready;

  always_comb begin
    state_nx = state;
    ptr_nx   = load_ptr;
    rdy_nx   = ld_ready;
    done_nx  = ld_done;
    case (state)
      IDLE: begin
        if (prog && !prog_q) begin
          state_nx = LOAD;
          ptr_nx   = '0;
          rdy_nx   = 1'b1;
        end
      end
      LOAD: begin
        if (!prog) begin
          state_nx = IDLE;
          ptr_nx   = '0;
          rdy_nx   = 1'b0;
        end else if (accept) begin
          ptr_nx = load_ptr + 1'b1;
          if (load_ptr == {ADDR_W{1'b1}}) begin
            state_nx = DONE;
            rdy_nx   = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!prog) begin
          state_nx = IDLE;
          done_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
        rdy_nx   = 1'b0;
        done_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      load_ptr <= '0;
      prog_q   <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      load_ptr <= ptr_nx;
      prog_q   <= prog;
      ld_ready <= rdy_nx;
      ld_done  <= done_nx;
    end
  end

  // A write wins over a read on the same edge.
  assign wr_en   = (run && we) || accept;
  assign rd_en   = run && !ce_n && !we;
  assign wr_addr = accept ? load_ptr : mar_addr;
  assign wr_data = accept ? ld_data : bus_in;

`ifdef RAM_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  assign rd_word = mem[mar_addr];

  // Array is never cleared; contents survive clr.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ram_out <= '0;
      ram_oe  <= 1'b0;
    end else begin
      ram_oe <= rd_en;
      if (rd_en)
        ram_out <= rd_word[DATA_W-1:0];
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      parity_err <= 1'b0;
    else if (rd_en)
      parity_err <= rd_word[DATA_W]
                    ^ (^rd_word[DATA_W-1:0]);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
